// File: rtl/game_state_controller_pkg.sv
// rtl/game_state_controller_pkg.sv - state encodings, default timing constants and timer sizing
package game_state_controller_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_RUNNING   = 2'd1,
        ST_INVULN    = 2'd2,
        ST_GAME_OVER = 2'd3
    } game_state_t;

    localparam int C_NUM_LIVES        = 3;
    localparam int C_INVULN_CYCLES    = 25_000_000;
    localparam int C_GAME_OVER_CYCLES = 50_000_000;

    // A single-cycle window still needs a one-bit timer, hence the floor of 1.
    function automatic int timer_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m <= 1) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/rise_edge_detect.sv
// rtl/rise_edge_detect.sv - registered-history rising edge detector
module rise_edge_detect (
    input  logic i_Clk,
    input  logic i_Rst_L,
    input  logic i_Sig,
    output logic o_Rise
);

    logic r_Sig_Q;

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_Sig_Q <= 1'b0;
        end else begin
            r_Sig_Q <= i_Sig;
        end
    end

    assign o_Rise = i_Sig & ~r_Sig_Q;

endmodule

// File: rtl/game_state_controller.sv
// rtl/game_state_controller.sv - game flow FSM: lives, start arming, invulnerability, game-over hold
module game_state_controller
    import game_state_controller_pkg::*;
#(
    parameter int NUM_LIVES        = C_NUM_LIVES,
    parameter int INVULN_CYCLES    = C_INVULN_CYCLES,
    parameter int GAME_OVER_CYCLES = C_GAME_OVER_CYCLES,
    parameter int C_BONUS_LIFE_EN  = 1
) (
    input  logic                 i_Clk,
    input  logic                 i_Rst_L,
    input  logic                 i_Start,
    input  logic                 i_Collision,
    input  logic                 i_Level_Up,
    output logic                 o_Game_Active,
    output logic                 o_Respawn,
    output logic                 o_Game_Over,
    output logic [NUM_LIVES-1:0] o_Lives,
    output logic [1:0]           o_State
);

    localparam int TW = timer_width(INVULN_CYCLES, GAME_OVER_CYCLES);
    localparam logic [TW-1:0]        INVULN_LOAD    = TW'(INVULN_CYCLES - 1);
    localparam logic [TW-1:0]        GAME_OVER_LOAD = TW'(GAME_OVER_CYCLES - 1);
    localparam logic [NUM_LIVES-1:0] LIVES_FULL     = '1;
    localparam logic [NUM_LIVES-1:0] LIVES_LAST     = NUM_LIVES'(1);

    game_state_t          r_State, next_state;
    logic [TW-1:0]        r_Timer, next_timer;
    logic [NUM_LIVES-1:0] r_Lives, next_lives;
    logic                 r_Armed, next_armed;
    logic                 r_Respawn, next_respawn;
    logic                 r_Game_Over, r_Game_Active;
    logic                 w_Go, w_Hit;
    logic [NUM_LIVES-1:0] w_Bonus_Lives;

    rise_edge_detect u_start_edge (
        .i_Clk   (i_Clk),
        .i_Rst_L (i_Rst_L),
        .i_Sig   (i_Start),
        .o_Rise  (w_Go)
    );

    rise_edge_detect u_collision_edge (
        .i_Clk   (i_Clk),
        .i_Rst_L (i_Rst_L),
        .i_Sig   (i_Collision),
        .o_Rise  (w_Hit)
    );

    assign w_Bonus_Lives = (C_BONUS_LIFE_EN != 0 && r_Lives != LIVES_FULL)
                         ? ((r_Lives << 1) | LIVES_LAST) : r_Lives;

    always_comb begin
        next_state   = r_State;
        next_timer   = r_Timer;
        next_lives   = r_Lives;
        next_armed   = r_Armed;
        next_respawn = 1'b0;
        case (r_State)
            ST_IDLE: begin
                // Arming on a low start level stops a held switch from auto-starting.
                if (!i_Start) begin
                    next_armed = 1'b1;
                end
                if (w_Go && r_Armed) begin
                    next_state = ST_RUNNING;
                    next_lives = LIVES_FULL;
                    next_armed = 1'b0;
                end
            end
            ST_RUNNING: begin
                if (w_Hit) begin
                    next_respawn = 1'b1;
                    next_lives   = r_Lives >> 1;
                    if (r_Lives == LIVES_LAST) begin
                        next_state = ST_GAME_OVER;
                        next_timer = GAME_OVER_LOAD;
                    end else begin
                        next_state = ST_INVULN;
                        next_timer = INVULN_LOAD;
                    end
                end else if (i_Level_Up) begin
                    next_lives = w_Bonus_Lives;
                end
            end
            ST_INVULN: begin
                if (i_Level_Up) begin
                    next_lives = w_Bonus_Lives;
                end
                if (r_Timer == '0) begin
                    next_state = ST_RUNNING;
                end else begin
                    next_timer = r_Timer - 1'b1;
                end
            end
            ST_GAME_OVER: begin
                if (r_Timer == '0) begin
                    next_state = ST_IDLE;
                    next_lives = LIVES_FULL;
                    next_armed = 1'b0;
                end else begin
                    next_timer = r_Timer - 1'b1;
                end
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_State       <= ST_IDLE;
            r_Timer       <= '0;
            r_Lives       <= LIVES_FULL;
            r_Armed       <= 1'b0;
            r_Respawn     <= 1'b0;
            r_Game_Over   <= 1'b0;
            r_Game_Active <= 1'b0;
        end else begin
            r_State       <= next_state;
            r_Timer       <= next_timer;
            r_Lives       <= next_lives;
            r_Armed       <= next_armed;
            r_Respawn     <= next_respawn;
            r_Game_Over   <= (next_state == ST_GAME_OVER);
            r_Game_Active <= (next_state == ST_RUNNING) || (next_state == ST_INVULN);
        end
    end

    assign o_State       = r_State;
    assign o_Lives       = r_Lives;
    assign o_Respawn     = r_Respawn;
    assign o_Game_Over   = r_Game_Over;
    assign o_Game_Active = r_Game_Active;

endmodule

// File: tb/tb_game_state_controller.sv
// tb/tb_game_state_controller.sv - directed and randomized checks against a lives-count model
module tb_game_state_controller;

    localparam int NL  = 3;
    localparam int INV = 4;
    localparam int GO  = 6;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b1;
    logic          coll = 1'b0;
    logic          lvl = 1'b0;
    logic          active, respawn, over;
    logic [NL-1:0] lives;
    logic [1:0]    state;

    int checks = 0;
    int failures = 0;

    game_state_controller #(
        .NUM_LIVES        (NL),
        .INVULN_CYCLES    (INV),
        .GAME_OVER_CYCLES (GO),
        .C_BONUS_LIFE_EN  (1)
    ) dut (
        .i_Clk         (clk),
        .i_Rst_L       (rst_n),
        .i_Start       (start),
        .i_Collision   (coll),
        .i_Level_Up    (lvl),
        .o_Game_Active (active),
        .o_Respawn     (respawn),
        .o_Game_Over   (over),
        .o_Lives       (lives),
        .o_State       (state)
    );

    always #5 clk = ~clk;

    // Model: state as 0..3, lives as a count, timer as clocks remaining in the current hold.
    int m_state = 0;
    int m_lives = NL;
    int m_left  = 0;
    bit m_armed = 1'b0;
    bit m_resp  = 1'b0;
    bit p_start = 1'b0;
    bit p_coll  = 1'b0;
    bit m_hit, m_go;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_state = 0; m_lives = NL; m_left = 0; m_armed = 0; m_resp = 0;
            p_start = 0; p_coll = 0;
        end else begin
            m_hit  = coll && !p_coll;
            m_go   = start && !p_start;
            m_resp = 0;
            case (m_state)
                0: begin
                    if (m_go && m_armed) begin
                        m_state = 1; m_lives = NL; m_armed = 0;
                    end else if (!start) begin
                        m_armed = 1;
                    end
                end
                1: begin
                    if (m_hit) begin
                        m_resp = 1;
                        m_lives = m_lives - 1;
                        if (m_lives == 0) begin m_state = 3; m_left = GO; end
                        else begin m_state = 2; m_left = INV; end
                    end else if (lvl && m_lives < NL) begin
                        m_lives = m_lives + 1;
                    end
                end
                2: begin
                    if (lvl && m_lives < NL) m_lives = m_lives + 1;
                    m_left = m_left - 1;
                    if (m_left == 0) m_state = 1;
                end
                default: begin
                    m_left = m_left - 1;
                    if (m_left == 0) begin m_state = 0; m_lives = NL; m_armed = 0; end
                end
            endcase
            p_start = start;
            p_coll  = coll;
        end
    end

    function automatic logic [NL-1:0] thermo(input int n);
        return NL'((1 << n) - 1);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            chk("model_state", state, m_state);
            chk("model_lives", lives, thermo(m_lives));
            chk("model_respawn", respawn, m_resp);
            chk("model_active", active, (m_state == 1 || m_state == 2));
            chk("model_game_over", over, (m_state == 3));
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    initial begin
        // 1: start held through reset release never auto-starts
        tick(); tick();
        rst_n = 1'b1;
        tick(); tick(); tick();
        chk("t1_idle_held", state, 0);
        chk("t1_lives_full", lives, 3'b111);
        chk("t1_inactive", active, 0);
        start = 1'b0; tick();
        chk("t1_armed_idle", state, 0);
        start = 1'b1; tick();
        chk("t1_running", state, 1);
        chk("t1_active", active, 1);

        // 2: first hit, 4-clock INVULN, second edge inside window ignored
        coll = 1'b1; tick();
        chk("t2_respawn", respawn, 1);
        chk("t2_lives", lives, 3'b011);
        chk("t2_inv1", state, 2);
        coll = 1'b0; tick();
        chk("t2_respawn_once", respawn, 0);
        chk("t2_inv2", state, 2);
        coll = 1'b1; tick();
        chk("t2_inv3", state, 2);
        chk("t2_ignored_lives", lives, 3'b011);
        chk("t2_ignored_resp", respawn, 0);
        coll = 1'b0; tick();
        chk("t2_inv4", state, 2);
        tick();
        chk("t2_back_running", state, 1);

        // 3: remaining hits down to game over, then 6-clock hold
        coll = 1'b1; tick();
        chk("t3_lives_001", lives, 3'b001);
        coll = 1'b0;
        repeat (4) tick();
        chk("t3_running_again", state, 1);
        coll = 1'b1; tick();
        coll = 1'b0;
        chk("t3_lives_000", lives, 3'b000);
        chk("t3_fatal_respawn", respawn, 1);
        for (int i = 0; i < GO; i++) begin
            chk("t3_game_over_hold", over, 1);
            tick();
        end
        chk("t3_idle", state, 0);
        chk("t3_lives_restored", lives, 3'b111);
        tick(); tick();
        chk("t3_no_autostart", state, 0);

        // 4: bonus lives and hit/level-up collision
        start = 1'b0; tick();
        start = 1'b1; tick();
        coll = 1'b1; tick(); coll = 1'b0; repeat (4) tick();
        coll = 1'b1; tick(); coll = 1'b0; repeat (4) tick();
        chk("t4_lives_001", lives, 3'b001);
        lvl = 1'b1; tick();
        chk("t4_bonus_011", lives, 3'b011);
        tick();
        chk("t4_bonus_111", lives, 3'b111);
        tick();
        lvl = 1'b0;
        chk("t4_full_noop", lives, 3'b111);
        coll = 1'b1; tick(); coll = 1'b0; repeat (4) tick();
        chk("t4_pre_lives", lives, 3'b011);
        coll = 1'b1; lvl = 1'b1; tick();
        coll = 1'b0; lvl = 1'b0;
        chk("t4_hit_wins", lives, 3'b001);
        chk("t4_hit_invuln", state, 2);

        // 5: async reset mid-INVULN
        tick();
        #1;
        rst_n = 1'b0;
        #1;
        chk("t5_state", state, 0);
        chk("t5_lives", lives, 3'b111);
        chk("t5_respawn", respawn, 0);
        chk("t5_active", active, 0);
        chk("t5_over", over, 0);
        tick();
        rst_n = 1'b1;

        // Randomized play against the model
        for (int i = 0; i < 4000; i++) begin
            tick();
            if ($urandom_range(0, 499) == 0) begin
                rst_n = 1'b0;
                tick();
                rst_n = 1'b1;
            end
            if ($urandom_range(0, 7) == 0) start = ~start;
            if ($urandom_range(0, 4) == 0) coll = ~coll;
            lvl = ($urandom_range(0, 9) == 0);
        end
        tick(); tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
